// File: rtl/req_pulse_scheduler_pkg.sv
// Shared types and constants for the request pulse scheduler.
// Holds FSM state encodings, requester count, wait-counter width and
// the round-robin pick helper used by the top-level arbiter.
package req_pulse_scheduler_pkg;

  localparam int N_REQ_C = 4;
  localparam int CNT_W   = 8;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_START = 2'b01,
    S_WAIT  = 2'b10
  } state_t;

  // Round-robin pick: scan from ptr+1 upward with wrap; the first set bit
  // wins. k == N_REQ_C wraps back onto ptr itself, so the last-served
  // requester is considered only after everyone else.
  function automatic logic [1:0] rr_pick(input logic [N_REQ_C-1:0] req,
                                         input logic [1:0]         ptr);
    logic [1:0] idx;
    logic [1:0] pick;
    logic       found;
    pick  = ptr;
    found = 1'b0;
    for (int k = 1; k <= N_REQ_C; k++) begin
      idx = ptr + 2'(k);
      if (!found && req[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/req_pulse_scheduler_edge_det.sv
// Purpose: rising-edge detector for one level request line.
// Latency: rise is combinational from level vs. the registered previous level.
// Backpressure: none; one pulse per 0->1 transition seen at a clock edge.
// Ports: clk, rst (sync, active-high), level (request level), rise (edge pulse).
module level_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic level,
  output logic rise
);

  logic prev_q;

  // prev clears in reset so a level held through reset counts as new.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q <= 1'b0;
    end else begin
      prev_q <= level;
    end
  end

  assign rise = level & ~prev_q;

endmodule

// File: rtl/req_pulse_scheduler.sv
// Purpose: latch request edges and launch one round-robin grant at a time.
// Latency: edge -> pending next cycle -> start the cycle after; WAIT until done/timeout.
// Backpressure: one grant outstanding; new edges queue in pending (merged, not counted).
// Ports: clk, rst (sync, active-high), level[N_REQ], done -> start, grant_id,
//        busy, pending[N_REQ], err (sticky timeout).
module req_pulse_scheduler
  import req_pulse_scheduler_pkg::*;
#(
  parameter int N_REQ   = N_REQ_C,
  parameter int TIMEOUT = 200
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] level,
  input  logic             done,
  output logic             start,
  output logic [1:0]       grant_id,
  output logic             busy,
  output logic [N_REQ-1:0] pending,
  output logic             err
);

  state_t             state_q, state_d;
  logic [N_REQ-1:0]   pending_q, pending_d;
  logic [1:0]         rr_ptr_q, rr_ptr_d;
  logic [1:0]         grant_id_q, grant_id_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               err_q, err_d;
  logic [N_REQ-1:0]   rise;

  for (genvar i = 0; i < N_REQ; i++) begin : g_edge
    level_edge_det u_edge (
      .clk   (clk),
      .rst   (rst),
      .level (level[i]),
      .rise  (rise[i])
    );
  end

  always_comb begin
    state_d    = state_q;
    pending_d  = pending_q | rise;
    rr_ptr_d   = rr_ptr_q;
    grant_id_d = grant_id_q;
    cnt_d      = cnt_q;
    err_d      = err_q;

    case (state_q)
      S_IDLE: begin
        // Selection is registered into grant_id so it is stable for START.
        if (|pending_q) begin
          grant_id_d = rr_pick(pending_q, rr_ptr_q);
          rr_ptr_d   = grant_id_d;
          state_d    = S_START;
        end
      end
      S_START: begin
        // Clear the served bit, but OR rise in afterwards so a fresh edge
        // on the same requester in this cycle is kept.
        pending_d = (pending_q & ~(N_REQ'(1) << grant_id_q)) | rise;
        cnt_d     = '0;
        state_d   = S_WAIT;
      end
      S_WAIT: begin
        if (done) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
          // cnt_q counts completed WAIT cycles, so this is the TIMEOUT-th.
          if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
            state_d = S_IDLE;
            err_d   = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      pending_q  <= '0;
      rr_ptr_q   <= 2'd3;
      grant_id_q <= 2'd0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      rr_ptr_q   <= rr_ptr_d;
      grant_id_q <= grant_id_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
    end
  end

  // Moore outputs straight from registers.
  assign start    = (state_q == S_START);
  assign busy     = (state_q == S_WAIT);
  assign grant_id = grant_id_q;
  assign pending  = pending_q;
  assign err      = err_q;

endmodule

// File: tb/tb_req_pulse_scheduler.sv
module tb_req_pulse_scheduler;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] level;
  logic       done;
  logic       start;
  logic [1:0] grant_id;
  logic       busy;
  logic [3:0] pending;
  logic       err;

  int total = 0;
  int bad   = 0;

  req_pulse_scheduler #(.N_REQ(4), .TIMEOUT(200)) dut (
    .clk      (clk),
    .rst      (rst),
    .level    (level),
    .done     (done),
    .start    (start),
    .grant_id (grant_id),
    .busy     (busy),
    .pending  (pending),
    .err      (err)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Advance one edge, then settle so outputs are sampled away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; level = 4'b0000; done = 1'b0;
    tick(); tick();
    rst = 1'b0;
  endtask

  // Wait for a start pulse, check it, then hold done off for done_after-1
  // WAIT cycles and raise it on the done_after-th WAIT cycle.
  task automatic expect_grant(input string tag, input int exp_id, input int done_after,
                              input logic [3:0] exp_pend);
    int n = 0;
    int bc;
    while (start !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    check_val({tag, "_start"}, 32'(start), 32'd1);
    check_val({tag, "_gid"}, 32'(grant_id), 32'(exp_id));
    tick();
    check_val({tag, "_nob2b"}, 32'(start), 32'd0);
    bc = int'(busy);
    for (int c = 1; c < done_after; c++) begin
      tick();
      bc += int'(busy);
    end
    done = 1'b1;
    tick();
    done = 1'b0;
    check_val({tag, "_busycyc"}, 32'(bc), 32'(done_after));
    check_val({tag, "_idle"}, 32'(busy), 32'd0);
    check_val({tag, "_pend"}, 32'(pending), 32'(exp_pend));
  endtask

  initial begin
    int n;
    int bc;
    int sc;
    rst = 1'b1; level = 4'b0000; done = 1'b0;

    // Reset state
    do_reset();
    check_val("rst_start", 32'(start), 32'd0);
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_pend", 32'(pending), 32'd0);
    check_val("rst_gid", 32'(grant_id), 32'd0);
    check_val("rst_err", 32'(err), 32'd0);

    // Single requester, done 3 cycles after start, level held
    level = 4'b0001;
    tick();
    check_val("t1_pend_lat", 32'(pending), 32'h1);
    check_val("t1_nostart", 32'(start), 32'd0);
    tick();
    check_val("t1_start_lat", 32'(start), 32'd1);
    expect_grant("t1", 0, 3, 4'b0000);
    sc = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      sc += int'(start);
    end
    check_val("t1_one_pulse", 32'(sc), 32'd0);

    // All four rise together from reset: 0,1,2,3
    do_reset();
    level = 4'b1111;
    tick();
    check_val("t2_pend", 32'(pending), 32'hF);
    expect_grant("t2g0", 0, 1, 4'b1110);
    expect_grant("t2g1", 1, 1, 4'b1100);
    expect_grant("t2g2", 2, 1, 4'b1000);
    expect_grant("t2g3", 3, 1, 4'b0000);

    // Round-robin wrap with rr_ptr = 1
    do_reset();
    level = 4'b0010;
    expect_grant("t3g1", 1, 1, 4'b0000);
    level = 4'b0000; tick();
    level = 4'b0111;
    expect_grant("t3a2", 2, 1, 4'b0011);
    expect_grant("t3a0", 0, 1, 4'b0010);
    expect_grant("t3a1", 1, 1, 4'b0000);
    level = 4'b0000; tick();
    level = 4'b0011;
    expect_grant("t3b0", 0, 1, 4'b0010);
    expect_grant("t3b1", 1, 1, 4'b0000);

    // Set wins over clear in START
    do_reset();
    level = 4'b0100;
    tick();
    level = 4'b0000;
    tick();
    check_val("t4_start", 32'(start), 32'd1);
    check_val("t4_gid", 32'(grant_id), 32'd2);
    level = 4'b0100;
    tick();
    check_val("t4_pend_kept", 32'(pending), 32'h4);
    check_val("t4_busy", 32'(busy), 32'd1);
    done = 1'b1; tick(); done = 1'b0;
    expect_grant("t4g2b", 2, 1, 4'b0000);

    // Timeout with done withheld
    do_reset();
    level = 4'b0001;
    n = 0;
    while (start !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    check_val("t5_start", 32'(start), 32'd1);
    tick();
    check_val("t5_err_early", 32'(err), 32'd0);
    bc = 0; n = 0;
    while (busy === 1'b1 && n < 300) begin
      bc++;
      tick();
      n++;
    end
    check_val("t5_waitcyc", 32'(bc), 32'd200);
    check_val("t5_err", 32'(err), 32'd1);
    check_val("t5_idle", 32'(busy), 32'd0);
    level = 4'b0000; tick();
    level = 4'b0010;
    expect_grant("t5g1", 1, 1, 4'b0000);
    check_val("t5_err_sticky", 32'(err), 32'd1);
    do_reset();
    check_val("t5_err_clr", 32'(err), 32'd0);

    // Reset mid-WAIT with levels held
    level = 4'b1000;
    tick();
    level = 4'b1001;
    tick();
    check_val("t6_start", 32'(start), 32'd1);
    check_val("t6_gid3", 32'(grant_id), 32'd3);
    tick();
    check_val("t6_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    tick();
    check_val("t6_r_start", 32'(start), 32'd0);
    check_val("t6_r_busy", 32'(busy), 32'd0);
    check_val("t6_r_pend", 32'(pending), 32'd0);
    check_val("t6_r_gid", 32'(grant_id), 32'd0);
    check_val("t6_r_err", 32'(err), 32'd0);
    rst = 1'b0;
    tick();
    check_val("t6_pend", 32'(pending), 32'h9);
    check_val("t6_nostart", 32'(start), 32'd0);
    tick();
    check_val("t6_start2", 32'(start), 32'd1);
    check_val("t6_gid0", 32'(grant_id), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
